// File: rtl/ifm_scan_ctrl_pkg.sv
// Shared command/mode codes and FSM state type for the IFM scan controller
// and the IFM window buffer it drives.
package ifm_pkg;

    localparam logic [2:0] IFM_ALL       = 3'b111;
    localparam logic [2:0] IFM_RIGHT     = 3'b001;
    localparam logic [2:0] IFM_DOWN      = 3'b010;
    localparam logic [2:0] IFM_LEFT      = 3'b100;
    localparam logic [2:0] IFM_NO_CHANGE = 3'b101;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_CONVOL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Number of SRAM reads a move needs: a full window or one new edge.
    function automatic logic [3:0] fetch_len(input logic [2:0] move);
        return (move == IFM_ALL) ? 4'd9 : 4'd3;
    endfunction

endpackage

// File: rtl/ifm_scan_ctrl_lane_packer.sv
// Steers each captured SRAM byte into its lane/byte slot for the current move.
// Lanes are cleared when a fetch begins so unused lanes read as zero.
module ifm_lane_packer
    import ifm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap_en,
    input  logic [3:0]       cap_idx,
    input  logic [2:0]       move,
    input  logic [7:0]       data,
    output logic [2:0][31:0] lanes_next
);

    logic [2:0][31:0] lanes_r;
    logic [1:0]       lane_s;
    logic [1:0]       pos_s;

    // Decode byte index to lane and position (position 0 lands in [23:16]).
    always_comb begin
        lane_s = 2'd0;
        pos_s  = 2'd0;
        case (move)
            IFM_ALL: begin
                if (cap_idx < 4'd3) begin
                    lane_s = 2'd0;
                    pos_s  = cap_idx[1:0];
                end else if (cap_idx < 4'd6) begin
                    lane_s = 2'd1;
                    pos_s  = 2'(cap_idx - 4'd3);
                end else begin
                    lane_s = 2'd2;
                    pos_s  = 2'(cap_idx - 4'd6);
                end
            end
            IFM_RIGHT: begin lane_s = 2'd0; pos_s = cap_idx[1:0]; end
            IFM_DOWN:  begin lane_s = 2'd1; pos_s = cap_idx[1:0]; end
            IFM_LEFT:  begin lane_s = 2'd2; pos_s = cap_idx[1:0]; end
            default:   begin lane_s = 2'd0; pos_s = 2'd0; end
        endcase
    end

    // Lanes including this cycle's capture, so the top can latch them on the last byte.
    always_comb begin
        lanes_next = lanes_r;
        if (cap_en) begin
            case (pos_s)
                2'd0:    lanes_next[lane_s][23:16] = data;
                2'd1:    lanes_next[lane_s][15:8]  = data;
                default: lanes_next[lane_s][7:0]   = data;
            endcase
        end else begin
            lanes_next = lanes_r;
        end
    end

    // Lane storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_r <= {3{32'h0000_0000}};
        end else if (clr) begin
            lanes_r <= {3{32'h0000_0000}};
        end else begin
            lanes_r <= lanes_next;
        end
    end

endmodule

// File: rtl/ifm_scan_ctrl.sv
// Serpentine 3x3 window scan over the IFM: fetches only the new pixels of each
// move, packs them into the buffer lanes and holds each window until acked.
module ifm_scan_ctrl
    import ifm_pkg::*;
#(
    parameter int IFM_W  = 5,
    parameter int IFM_H  = 5,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        ifm_read,
    output logic [1:0]        mode,
    output logic [2:0][31:0]  ifm_input,
    output logic              win_valid,
    input  logic              win_ack,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] COL_LAST = 8'(IFM_W - 3);
    localparam logic [7:0] ROW_LAST = 8'(IFM_H - 3);

    state_t           state_r, state_s;
    logic [2:0]       move_r, step_move_s;
    logic [3:0]       k_r, cap_idx_r;
    logic             cap_en_r, last_win_s;
    logic [7:0]       nrow_r, ncol_r, win_row_r, win_col_r, nxt_row_s, nxt_col_s;
    logic [2:0][31:0] ifm_input_r, lanes_next_s;
    logic [1:0]       off_r_s, off_c_s;
    logic [ADDR_W-1:0] pix_off_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next move: right on even window-rows, left on odd ones, down at a row end.
    always_comb begin
        step_move_s = IFM_NO_CHANGE;
        last_win_s  = 1'b0;
        nxt_row_s   = win_row_r;
        nxt_col_s   = win_col_r;
        if (!win_row_r[0] && (win_col_r < COL_LAST)) begin
            step_move_s = IFM_RIGHT;
            nxt_col_s   = win_col_r + 8'd1;
        end else if (win_row_r[0] && (win_col_r != 8'd0)) begin
            step_move_s = IFM_LEFT;
            nxt_col_s   = win_col_r - 8'd1;
        end else if (win_row_r < ROW_LAST) begin
            step_move_s = IFM_DOWN;
            nxt_row_s   = win_row_r + 8'd1;
        end else begin
            last_win_s  = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_s = (k_r == fetch_len(move_r) - 4'd1) ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: state_s = ST_ISSUE;
            ST_ISSUE: state_s = ST_HOLD;
            ST_HOLD: begin
                if (win_ack) state_s = last_win_s ? ST_DONE : ST_FETCH;
                else         state_s = ST_HOLD;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Pixel offset inside the new window for fetch request k.
    always_comb begin
        off_r_s = 2'd0;
        off_c_s = 2'd0;
        case (move_r)
            IFM_ALL: begin
                if (k_r < 4'd3) begin
                    off_r_s = 2'd0; off_c_s = k_r[1:0];
                end else if (k_r < 4'd6) begin
                    off_r_s = 2'd1; off_c_s = 2'(k_r - 4'd3);
                end else begin
                    off_r_s = 2'd2; off_c_s = 2'(k_r - 4'd6);
                end
            end
            IFM_RIGHT: begin off_r_s = k_r[1:0]; off_c_s = 2'd2;     end
            IFM_DOWN:  begin off_r_s = 2'd2;     off_c_s = k_r[1:0]; end
            IFM_LEFT:  begin off_r_s = k_r[1:0]; off_c_s = 2'd0;     end
            default:   begin off_r_s = 2'd0;     off_c_s = 2'd0;     end
        endcase
        pix_off_s = (ADDR_W'(nrow_r) + ADDR_W'(off_r_s)) * ADDR_W'(IFM_W)
                  + ADDR_W'(ncol_r) + ADDR_W'(off_c_s);
    end

    // Move, target position, fetch counter, capture pipeline and issued window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_r      <= IFM_NO_CHANGE;
            nrow_r      <= 8'd0;
            ncol_r      <= 8'd0;
            k_r         <= 4'd0;
            cap_en_r    <= 1'b0;
            cap_idx_r   <= 4'd0;
            win_row_r   <= 8'd0;
            win_col_r   <= 8'd0;
            ifm_input_r <= {3{32'h0000_0000}};
        end else begin
            k_r       <= (state_r == ST_FETCH) ? k_r + 4'd1 : 4'd0;
            cap_en_r  <= (state_r == ST_FETCH);
            cap_idx_r <= k_r;
            if (state_r == ST_IDLE && start) begin
                move_r <= IFM_ALL;
                nrow_r <= 8'd0;
                ncol_r <= 8'd0;
            end else if (state_r == ST_HOLD && win_ack && !last_win_s) begin
                move_r <= step_move_s;
                nrow_r <= nxt_row_s;
                ncol_r <= nxt_col_s;
            end
            // The last byte lands on this edge, so latch the lanes with it folded in.
            if (state_r == ST_DRAIN) begin
                win_row_r   <= nrow_r;
                win_col_r   <= ncol_r;
                ifm_input_r <= lanes_next_s;
            end
        end
    end

    ifm_lane_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        ((state_r != ST_FETCH) && (state_s == ST_FETCH)),
        .cap_en     (cap_en_r),
        .cap_idx    (cap_idx_r),
        .move       (move_r),
        .data       (mem_rdata[7:0]),
        .lanes_next (lanes_next_s)
    );

    // Output decode.
    always_comb begin
        busy      = (state_r != ST_IDLE);
        mode      = busy ? MODE_CONVOL : MODE_IDLE;
        mem_rd_en = (state_r == ST_FETCH);
        mem_addr  = mem_rd_en ? base_addr + pix_off_s : {ADDR_W{1'b0}};
        ifm_read  = (state_r == ST_ISSUE) ? move_r : IFM_NO_CHANGE;
        win_valid = (state_r == ST_HOLD);
        done      = (state_r == ST_DONE);
        win_row   = win_row_r;
        win_col   = win_col_r;
        ifm_input = ifm_input_r;
    end

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// Self-checking bench for ifm_scan_ctrl: geometric scan model plus directed
// latency, packing, ignored-input, reset and small-map cases.
module tb_ifm_scan_ctrl;
    import ifm_pkg::*;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: 5x5, B: 3x3, C: 3 wide x 5 high
    logic start_a, start_b, start_c, ack_a, ack_b, ack_c;
    logic [AW-1:0] base_a, base_b, base_c, addr_a, addr_b, addr_c;
    logic rd_a, rd_b, rd_c, wv_a, wv_b, wv_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [7:0] rdata_a, rdata_b, rdata_c, row_a, row_b, row_c, col_a, col_b, col_c;
    logic [2:0] rd_cmd_a, rd_cmd_b, rd_cmd_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic [2:0][31:0] in_a, in_b, in_c;

    ifm_scan_ctrl #(.IFM_W(5), .IFM_H(5), .ADDR_W(AW), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .mem_rd_en(rd_a),
        .mem_addr(addr_a), .mem_rdata(rdata_a), .ifm_read(rd_cmd_a), .mode(mode_a),
        .ifm_input(in_a), .win_valid(wv_a), .win_ack(ack_a), .win_row(row_a),
        .win_col(col_a), .busy(busy_a), .done(done_a));
    ifm_scan_ctrl #(.IFM_W(3), .IFM_H(3), .ADDR_W(AW), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .mem_rd_en(rd_b),
        .mem_addr(addr_b), .mem_rdata(rdata_b), .ifm_read(rd_cmd_b), .mode(mode_b),
        .ifm_input(in_b), .win_valid(wv_b), .win_ack(ack_b), .win_row(row_b),
        .win_col(col_b), .busy(busy_b), .done(done_b));
    ifm_scan_ctrl #(.IFM_W(3), .IFM_H(5), .ADDR_W(AW), .DATA_W(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .base_addr(base_c), .mem_rd_en(rd_c),
        .mem_addr(addr_c), .mem_rdata(rdata_c), .ifm_read(rd_cmd_c), .mode(mode_c),
        .ifm_input(in_c), .win_valid(wv_c), .win_ack(ack_c), .win_row(row_c),
        .win_col(col_c), .busy(busy_c), .done(done_c));

    // SRAMs with mem[a] = a (low byte), one cycle read latency
    always @(posedge clk) begin
        rdata_a <= rd_a ? addr_a[7:0] : 8'h00;
        rdata_b <= rd_b ? addr_b[7:0] : 8'h00;
        rdata_c <= rd_c ? addr_c[7:0] : 8'h00;
    end

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endfunction

    // ---------------- scan model for DUT A ----------------
    typedef struct {
        logic [2:0]       mv;
        logic [7:0]       r;
        logic [7:0]       c;
        logic [2:0][31:0] lanes;
    } win_t;

    win_t             exp_win[$];
    logic [AW-1:0]    exp_addr[$];
    logic [2:0][31:0] last_lanes;
    bit               model_on = 1'b0;
    int               mbase;
    win_t             cw;

    function automatic logic [AW-1:0] a_of(int r, int c);
        return AW'(mbase + r * 5 + c);
    endfunction
    function automatic logic [7:0] px(int r, int c);
        return 8'((mbase + r * 5 + c) & 255);
    endfunction
    function automatic logic [31:0] p3(logic [7:0] x, logic [7:0] y, logic [7:0] z);
        return {8'h00, x, y, z};
    endfunction

    task automatic model_build(input int base);
        int pr, pc, c;
        win_t w;
        mbase = base;
        exp_win.delete();
        exp_addr.delete();
        pr = -1;
        pc = -1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                c = (r % 2 == 0) ? i : 2 - i;
                w.r = 8'(r);
                w.c = 8'(c);
                w.lanes = {3{32'h0}};
                if (pr < 0) begin
                    w.mv = IFM_ALL;
                    for (int k = 0; k < 9; k++) exp_addr.push_back(a_of(r + k / 3, c + k % 3));
                    for (int k = 0; k < 3; k++) w.lanes[k] = p3(px(r + k, c), px(r + k, c + 1), px(r + k, c + 2));
                end else if (r > pr) begin
                    w.mv = IFM_DOWN;
                    for (int k = 0; k < 3; k++) exp_addr.push_back(a_of(r + 2, c + k));
                    w.lanes[1] = p3(px(r + 2, c), px(r + 2, c + 1), px(r + 2, c + 2));
                end else if (c > pc) begin
                    w.mv = IFM_RIGHT;
                    for (int k = 0; k < 3; k++) exp_addr.push_back(a_of(r + k, c + 2));
                    w.lanes[0] = p3(px(r, c + 2), px(r + 1, c + 2), px(r + 2, c + 2));
                end else begin
                    w.mv = IFM_LEFT;
                    for (int k = 0; k < 3; k++) exp_addr.push_back(a_of(r + k, c));
                    w.lanes[2] = p3(px(r, c), px(r + 1, c), px(r + 2, c));
                end
                exp_win.push_back(w);
                pr = r;
                pc = c;
            end
        end
    endtask

    // Compare DUT A against the model every cycle
    always @(negedge clk) begin
        if (!rst && model_on) begin
            if (rd_a) begin
                if (exp_addr.size() == 0) fail("unexpected_read");
                else chk("read_addr", 96'(addr_a), 96'(exp_addr.pop_front()));
            end
            if (rd_cmd_a != IFM_NO_CHANGE) begin
                if (exp_win.size() == 0) fail("unexpected_window");
                else begin
                    cw = exp_win.pop_front();
                    chk("ifm_read", 96'(rd_cmd_a), 96'(cw.mv));
                    chk("lanes", in_a, cw.lanes);
                    chk("win_row", 96'(row_a), 96'(cw.r));
                    chk("win_col", 96'(col_a), 96'(cw.c));
                    last_lanes = cw.lanes;
                end
            end else begin
                chk("lane_hold", in_a, last_lanes);
            end
            chk("mode", 96'(mode_a), busy_a ? 96'(MODE_CONVOL) : 96'(MODE_IDLE));
        end
    end

    // Recorders of issued windows
    logic [2:0]       mv_a[$], mv_b[$], mv_c[$];
    logic [2:0][31:0] ln_a[$], ln_b[$], ln_c[$];
    int               dn_b = 0, dn_c = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_cmd_a != IFM_NO_CHANGE) begin mv_a.push_back(rd_cmd_a); ln_a.push_back(in_a); end
            if (rd_cmd_b != IFM_NO_CHANGE) begin mv_b.push_back(rd_cmd_b); ln_b.push_back(in_b); end
            if (rd_cmd_c != IFM_NO_CHANGE) begin mv_c.push_back(rd_cmd_c); ln_c.push_back(in_c); end
            if (done_b) dn_b++;
            if (done_c) dn_c++;
        end
    end

    task automatic check_reset_a(input string tag);
        chk({tag, "_rd_en"}, 96'(rd_a), 96'(0));
        chk({tag, "_addr"}, 96'(addr_a), 96'(0));
        chk({tag, "_ifm_read"}, 96'(rd_cmd_a), 96'(3'b101));
        chk({tag, "_mode"}, 96'(mode_a), 96'(0));
        chk({tag, "_lanes"}, in_a, 96'(0));
        chk({tag, "_win_valid"}, 96'(wv_a), 96'(0));
        chk({tag, "_row_col"}, 96'({row_a, col_a}), 96'(0));
        chk({tag, "_busy_done"}, 96'({busy_a, done_a}), 96'(0));
    endtask

    task automatic check_seq_a(input string tag);
        logic [2:0] s[9];
        s = '{IFM_ALL, IFM_RIGHT, IFM_RIGHT, IFM_DOWN, IFM_LEFT, IFM_LEFT, IFM_DOWN, IFM_RIGHT, IFM_RIGHT};
        chk({tag, "_windows"}, 96'(mv_a.size()), 96'(9));
        for (int i = 0; i < 9 && i < mv_a.size(); i++) chk({tag, "_move"}, 96'(mv_a[i]), 96'(s[i]));
        chk({tag, "_model_reads_left"}, 96'(exp_addr.size()), 96'(0));
        chk({tag, "_model_wins_left"}, 96'(exp_win.size()), 96'(0));
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!done_a && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) fail({tag, "_done_timeout"});
    endtask

    initial begin
        int n;
        int lat_addr[9];
        lat_addr = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        rst = 1'b1;
        {start_a, start_b, start_c, ack_a, ack_b, ack_c} = 6'b0;
        base_a = '0; base_b = '0; base_c = '0;
        last_lanes = {3{32'h0}};
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        rst = 1'b0;
        @(negedge clk);

        // Latency, hold with no ack, then full scan with immediate acks
        model_build(0);
        model_on = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            chk("lat_rd_en", 96'(rd_a), 96'(cyc <= 9));
            if (cyc <= 9) chk("lat_addr", 96'(addr_a), 96'(lat_addr[cyc - 1]));
            if (cyc == 10) chk("lat_drain_cmd", 96'(rd_cmd_a), 96'(3'b101));
            if (cyc == 11) begin
                chk("lat_all_cmd", 96'(rd_cmd_a), 96'(3'b111));
                chk("all_lane0", 96'(in_a[0]), 96'(32'h0000_0102));
                chk("all_lane1", 96'(in_a[1]), 96'(32'h0005_0607));
                chk("all_lane2", 96'(in_a[2]), 96'(32'h000A_0B0C));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            chk("hold_valid", 96'(wv_a), 96'(1));
            chk("hold_no_read", 96'(rd_a), 96'(0));
            @(negedge clk);
        end
        ack_a = 1'b1;
        wait_done_a("scan1");
        chk("done_busy", 96'(busy_a), 96'(1));
        @(negedge clk);
        chk("after_done", 96'({busy_a, done_a}), 96'(0));
        ack_a = 1'b0;
        check_seq_a("scan1");
        if (ln_a.size() >= 5) begin
            chk("right1_lane0", 96'(ln_a[1][0]), 96'(32'h0003_080D));
            chk("right2_lane0", 96'(ln_a[2][0]), 96'(32'h0004_090E));
            chk("down_lane1", 96'(ln_a[3][1]), 96'(32'h0011_1213));
            chk("left1_lane2", 96'(ln_a[4][2]), 96'(32'h0006_0B10));
        end else fail("scan1_lane_record");

        // start during HOLD and win_ack during FETCH are ignored
        mv_a.delete(); ln_a.delete();
        base_a = AW'(100);
        model_build(100);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int w = 0; w < 9; w++) begin
            n = 0;
            while (!wv_a && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) fail("ign_wait_valid");
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            ack_a = 1'b1;
            @(negedge clk);
            ack_a = 1'b0;
            if (w < 8) begin
                n = 0;
                while (!rd_a && n < 100) begin @(negedge clk); n++; end
                if (n >= 100) fail("ign_wait_fetch");
                ack_a = 1'b1;
                @(negedge clk);
                ack_a = 1'b0;
            end
        end
        wait_done_a("ignore");
        check_seq_a("ignore");
        @(negedge clk);

        // Reset during fetch of the 4th window, then rescan
        mv_a.delete(); ln_a.delete();
        base_a = '0;
        model_build(0);
        start_a = 1'b1;
        ack_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(mv_a.size() == 3 && rd_a) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("rst_wait_fetch4");
        rst = 1'b1;
        model_on = 1'b0;
        ack_a = 1'b0;
        #1;
        check_reset_a("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last_lanes = {3{32'h0}};
        @(negedge clk);
        mv_a.delete(); ln_a.delete();
        model_build(0);
        model_on = 1'b1;
        start_a = 1'b1;
        ack_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("rescan");
        ack_a = 1'b0;
        check_seq_a("rescan");
        @(negedge clk);

        // Small maps: 3x3 and 3 wide x 5 high
        start_b = 1'b1; start_c = 1'b1; ack_b = 1'b1; ack_c = 1'b1;
        @(negedge clk);
        start_b = 1'b0; start_c = 1'b0;
        n = 0;
        while ((dn_b == 0 || dn_c == 0) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("small_done_timeout");
        repeat (3) @(negedge clk);
        ack_b = 1'b0; ack_c = 1'b0;
        chk("b_windows", 96'(mv_b.size()), 96'(1));
        chk("b_done_pulses", 96'(dn_b), 96'(1));
        if (mv_b.size() >= 1) begin
            chk("b_move", 96'(mv_b[0]), 96'(3'b111));
            chk("b_lanes", ln_b[0], {32'h0006_0708, 32'h0003_0405, 32'h0000_0102});
        end
        chk("c_windows", 96'(mv_c.size()), 96'(3));
        chk("c_done_pulses", 96'(dn_c), 96'(1));
        if (mv_c.size() >= 3) begin
            chk("c_move0", 96'(mv_c[0]), 96'(3'b111));
            chk("c_move1", 96'(mv_c[1]), 96'(3'b010));
            chk("c_move2", 96'(mv_c[2]), 96'(3'b010));
            chk("c_down1", ln_c[1], {32'h0, 32'h0009_0A0B, 32'h0});
            chk("c_down2", ln_c[2], {32'h0, 32'h000C_0D0E, 32'h0});
        end
        chk("c_idle", 96'({busy_b, busy_c}), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ifm_scan_ctrl.md
Name: ifm_scan_ctrl

Overview:
Drives the 3x3 IFM window buffer for convolution in a serpentine scan. It walks the window over an IFM_W x IFM_H feature map: right across even window-rows, down at the row end, then left across odd window-rows. For each move it reads only the new pixels from IFM SRAM, packs them into the buffer's 3 x 32-bit input lanes, and issues the matching ifm_read command. It holds each window until the PE array acknowledges it, then moves on.

Parameters:
IFM_W, 5, feature-map width in pixels; must be at least 3.
IFM_H, 5, feature-map height in pixels; must be at least 3.
ADDR_W, 10, IFM SRAM address width.
DATA_W, 8, pixel width; fixed at 8 by the lane packing.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  begin a scan; sampled only in IDLE.
base_addr  input  ADDR_W  SRAM address of pixel (0,0); row-major, address = base + row*IFM_W + col.
mem_rd_en  output  1  SRAM read request.
mem_addr  output  ADDR_W  SRAM read address.
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
ifm_read  output  3  buffer command: ALL 3'b111, RIGHT 3'b001, DOWN 3'b010, LEFT 3'b100, NO_CHANGE 3'b101.
mode  output  2  buffer mode: CONVOL 2'b01 while busy, 2'b00 otherwise.
ifm_input  output  3x32  packed lanes [0..2] to the buffer.
win_valid  output  1  current window is loaded and stable.
win_ack  input  1  PE array has finished with the current window.
win_row, win_col  output  8 each  top-left coordinate of the current window.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle pulse after the last window is acknowledged.

Behaviour:
- Reset: state IDLE. mem_rd_en=0, mem_addr=0, ifm_read=NO_CHANGE, mode=0, ifm_input lanes=0, win_valid=0, win_row=0, win_col=0, busy=0, done=0. Reset mid-scan aborts immediately; no drain.
- States and transitions:
  - IDLE: start -> FETCH with move=ALL, row=0, col=0, dir=right.
  - FETCH: assert mem_rd_en for N consecutive cycles (N=9 for ALL, 3 otherwise), then -> DRAIN.
  - DRAIN: 1 cycle; captures the last byte; -> ISSUE.
  - ISSUE: 1 cycle; ifm_read=move, ifm_input holds the packed lanes; -> HOLD.
  - HOLD: win_valid=1; on win_ack -> next move, or DONE if this was the last window.
  - DONE: 1 cycle; done=1; -> IDLE.
- ifm_read=NO_CHANGE in every state except ISSUE.
- Byte capture: the byte for request k is captured in the cycle after request k.
- Lane packing. Bits [31:24] are always 0. Lanes not used by a move are driven to 0. Lanes hold their value outside ISSUE.
  - ALL: lane r = {row r col 0, col 1, col 2} in [23:16],[15:8],[7:0]. Fetch order is row-major.
  - RIGHT: lane0 = new right column, rows top to bottom.
  - DOWN: lane1 = new bottom row, columns left to right.
  - LEFT: lane2 = new left column, rows top to bottom.
- Move sequence:
  - On an even window-row, RIGHT until col=IFM_W-3. On an odd window-row, LEFT until col=0.
  - At the row end: DOWN if row<IFM_H-3, else DONE.
  - Total windows = (IFM_H-2)*(IFM_W-2).
  - IFM_W=3 gives only DOWN moves; IFM_H=3 gives one row; IFM_W=IFM_H=3 gives a single ALL then DONE.
- win_row and win_col update in ISSUE to the new window position.
- Latency: start in cycle 0 gives reads in cycles 1-9, DRAIN in cycle 10, ifm_read=ALL in cycle 11. Each later move takes 5 cycles from the ack cycle to ISSUE.
- Ignored inputs: start while busy; win_ack outside HOLD. win_ack held high acknowledges each window in its first HOLD cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap is the caller's responsibility.

Decomposition:
- Package ifm_pkg holds the ifm_read command codes, the mode codes, and the state enum typedef. IFM_BUF shares the command and mode codes.
- One sub-module, ifm_lane_packer: byte-index and move to lane/bit-slice writes, with lane clear at FETCH entry. The counters and FSM stay in the top.

Test Plan:
- Full scan, IFM_W=IFM_H=5, base=0, mem[a]=a, immediate acks -> ifm_read sequence ALL,R,R,D,L,L,D,R,R. Then done pulse; busy drops the following cycle; 9 windows total.
- Packing, same setup:
  - ALL gives lanes 0x00000102, 0x00050607, 0x000A0B0C.
  - First RIGHT gives lane0=0x0003080D; second RIGHT gives 0x0004090E.
  - DOWN gives lane1=0x00111213.
  - First LEFT gives lane2=0x00060B10.
- Latency: start at cycle 0 -> mem_rd_en high cycles 1-9 with addrs 0,1,2,5,6,7,10,11,12; ifm_read=ALL at cycle 11. win_ack held off for 20 cycles -> win_valid stays 1 and no reads are issued.
- Boundary, IFM_W=IFM_H=3 -> single ALL, then done. IFM_W=3, IFM_H=5 -> ALL,D,D.
- start pulsed during HOLD and win_ack pulsed during FETCH -> both ignored; the move sequence is unchanged.
- rst asserted during FETCH of the 4th window -> all outputs at reset values asynchronously. A new start afterwards rescans from (0,0) with ALL.
